// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_core front end.
//   XLEN          default data/address width
//   RESET_PC      default first fetch address after reset
//   INSTR_NOP     canonical no-op encoding (addi x0,x0,0)
//   fetch_state_t fetch sequencer states
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer with flush.
//   clk, reset        clock, asynchronous active-high reset
//   flush             discard all entries (a push in the same cycle lands as the only entry)
//   push, push_data   write one entry; dropped when full unless a pop frees a slot
//   pop               consume the head entry (ignored when empty or flushing)
//   head_valid        buffer not empty
//   head_data         head entry, read straight from storage registers
//   count             number of entries held
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_FULL) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      if (push) begin
        mem[0] <= push_data;
        wr_ptr <= PTR_ONE;
        count  <= CNT_ONE;
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of cpu_core. Owns the PC, issues word reads
// to instruction ROM (one outstanding), buffers words in fetch_fifo and
// presents {pc, instr} to decode. Redirects flush all wrong-path words.
//   clk, reset                      clock, asynchronous active-high reset
//   imem_req_valid/addr/ready       ROM read request (word-aligned address)
//   imem_rsp_valid/data             ROM read response, in order
//   redirect_valid/pc               branch/jump target from execute
//   instr_valid/ready/data/pc       buffered instruction to decode
//   instr_fault                     head entry is a misaligned-target fault
// Optional feature macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect pushes
// a single fault entry and halts fetch until the next redirect. Without it
// the low two target bits are cleared and instr_fault is tied low.
//
// state | meaning
// IDLE  | first cycle out of reset, nothing issued
// REQ   | request ROM read when the buffer can hold the reply
// WAIT  | one read outstanding, reply is pushed on arrival
// DROP  | one stale read outstanding, reply is discarded
module instr_fetch_unit #(
  parameter int              XLEN       = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault
);
  import cpu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [CW-1:0]   FIFO_FULL  = CW'(FIFO_DEPTH);
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam int EW = 2*XLEN + 1;
`else
  localparam int EW = 2*XLEN;
`endif

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   push_entry;
  logic [EW-1:0]   head_entry;
  logic            fifo_push;
  logic            req_fire;
  logic            stale_in_flight;
  logic            halted;

  // Only REQ has no read outstanding, so a free slot there covers the reply.
  assign imem_req_valid = (state == REQ) && !halted && (fifo_count < FIFO_FULL);
  assign imem_req_addr  = fetch_pc & ALIGN_MASK;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // After a redirect, a read accepted this cycle or still unanswered must be drained.
  assign stale_in_flight = req_fire ||
                           (((state == WAIT) || (state == DROP)) && !imem_rsp_valid);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fifo_push  = ((state == WAIT) && imem_rsp_valid && !redirect_valid) || misaligned;
  assign push_entry = misaligned ? {redirect_pc, {XLEN{1'b0}}, 1'b1}
                                 : {fetch_pc, imem_rsp_data, 1'b0};
  assign instr_pc    = head_entry[2*XLEN:XLEN+1];
  assign instr_data  = head_entry[XLEN:1];
  assign instr_fault = head_entry[0];
`else
  assign halted      = 1'b0;
  assign fifo_push   = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign push_entry  = {fetch_pc, imem_rsp_data};
  assign instr_pc    = head_entry[2*XLEN-1:XLEN];
  assign instr_data  = head_entry[XLEN-1:0];
  assign instr_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      halted   <= 1'b0;
`endif
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
      state    <= stale_in_flight ? DROP : REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      halted   <= misaligned;
`endif
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ:  if (req_fire) state <= WAIT;
        WAIT: if (imem_rsp_valid) begin
          fetch_pc <= fetch_pc + PC_STEP;
          state    <= REQ;
        end
        DROP: if (imem_rsp_valid) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

  // The pop in a redirect cycle was already taken by decode; flush covers the rest.
  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (instr_ready),
    .head_valid (instr_valid),
    .head_data  (head_entry),
    .count      (fifo_count)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_fault;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_fault(instr_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ROM model: one accepted read answered after a latency in [lat_lo+1, lat_hi+1] cycles.
  bit          pend = 0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          lat_lo = 0, lat_hi = 0;
  int          rom_mode = 1, cons_mode = 1;  // 0 never, 1 always, 2 random

  // Reference: delivered stream is sequential words from the last redirect target.
  logic [31:0] exp_pc = RST_PC;
  bit          model_on = 1;
  int          seg_cnt = 0;
  logic [31:0] seg_first = '0, seg_last = '0;
  int          xfer_now = 0, xfer_total = 0;

  typedef struct {
    logic [31:0] target;
    int          n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit pick(input int mode);
    if (mode == 2) return bit'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 0);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_instr_pc"}, instr_pc, 0);
    check({tag, "_instr_data"}, instr_data, 0);
    check({tag, "_instr_fault"}, instr_fault, 0);
  endtask

  // Called at posedge+1; drives one cycle of inputs, checks, advances one clock.
  task automatic tick(input bit redir, input logic [31:0] tgt);
    imem_rsp_valid = pend && (pend_cnt == 0);
    imem_rsp_data  = pend ? rom_word(pend_addr) : 32'hDEAD_BEEF;
    imem_req_ready = pick(rom_mode);
    instr_ready    = pick(cons_mode);
    redirect_valid = redir;
    redirect_pc    = tgt;
    #1;
    if (imem_req_valid) check("req_align", imem_req_addr[1:0], 0);
    xfer_now = 0;
    if (instr_valid && instr_ready) begin
      xfer_now = 1;
      xfer_total++;
      if (model_on) begin
        check("xfer_pc", instr_pc, exp_pc);
        check("xfer_data", instr_data, rom_word(exp_pc));
        check("xfer_fault", instr_fault, 0);
        exp_pc = exp_pc + 32'd4;
      end
      if (seg_cnt == 0) seg_first = instr_pc;
      seg_last = instr_pc;
      seg_cnt++;
    end
    if (redir) begin
      exp_pc  = tgt & ~32'h3;
      seg_cnt = 0;
    end
    if (imem_rsp_valid) pend = 0;
    if (imem_req_valid && imem_req_ready) begin
      check("one_outstanding", {31'b0, pend}, 0);
      pend      = 1;
      pend_addr = imem_req_addr;
      pend_cnt  = $urandom_range(lat_lo, lat_hi);
    end else if (pend && pend_cnt > 0) begin
      pend_cnt--;
    end
    @(posedge clk);
    #1;
    if (redir && (!TRAP || tgt[1:0] == 2'b00)) check("flush_valid", instr_valid, 0);
  endtask

  task automatic run_words(input int n, input int budget, input string name);
    int c = 0;
    while (seg_cnt < n && c < budget) begin
      tick(1'b0, 32'h0);
      c++;
    end
    check({name, "_timeout"}, (seg_cnt >= n), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_rsp_valid = 0; imem_req_ready = 0; instr_ready = 0; redirect_valid = 0;
    #1;
    rst_checks("rst");
    repeat (2) @(posedge clk);
    #1;
    pend = 0; exp_pc = RST_PC; seg_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic find_cycle(input bit need_valid, input bit rsp_now, input string name);
    int c = 0;
    while (!(pend && ((pend_cnt == 0) == rsp_now) && (!need_valid || instr_valid)) && c < 60) begin
      tick(1'b0, 32'h0);
      c++;
    end
    check({name, "_found"}, (c < 60), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int req_seen;
    reset = 1'b1;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; instr_ready = 0;
    @(posedge clk); #1;
    do_reset();

    // 1: sequential stream from reset
    rom_mode = 1; cons_mode = 1; lat_lo = 0; lat_hi = 0;
    run_words(4, 40, "t1");
    check("t1_first", seg_first, RST_PC);
    check("t1_last", seg_last, RST_PC + 32'd12);

    // 2: decode stalls, buffer fills to depth, no request without room
    cons_mode = 0;
    repeat (10) tick(1'b0, 32'h0);
    check("t2_req_blocked", imem_req_valid, 0);
    check("t2_no_outstanding", {31'b0, pend}, 0);
    check("t2_valid", instr_valid, 1);
    rom_mode = 0; cons_mode = 1; n0 = seg_cnt;
    repeat (6) tick(1'b0, 32'h0);
    check("t2_buffered", seg_cnt - n0, 2);
    rom_mode = 1;
    run_words(seg_cnt + 2, 40, "t2_release");

    // 3: redirect while a read is outstanding
    lat_lo = 2; lat_hi = 2;
    find_cycle(1'b0, 1'b0, "t3");
    tick(1'b1, 32'h40);
    run_words(1, 40, "t3");
    check("t3_next_pc", seg_first, 32'h40);

    // 4: redirect, response and pop in the same cycle
    lat_lo = 0; lat_hi = 0; cons_mode = 0;
    find_cycle(1'b1, 1'b1, "t4");
    cons_mode = 1;
    tick(1'b1, 32'h200);
    check("t4_pop", xfer_now, 1);
    run_words(2, 40, "t4");
    check("t4_next_pc", seg_first, 32'h200);
    check("t4_second_pc", seg_last, 32'h204);

    // 5: reset while waiting, stale response afterwards ignored
    lat_lo = 2; lat_hi = 2; cons_mode = 1;
    find_cycle(1'b0, 1'b0, "t5");
    reset = 1'b1;
    #1;
    rst_checks("t5_rst");
    @(posedge clk); #1;
    reset = 1'b0; exp_pc = RST_PC; seg_cnt = 0;
    rom_mode = 0;
    repeat (3) begin
      pend = 1; pend_cnt = 0; pend_addr = 32'h44;
      tick(1'b0, 32'h0);
      check("t5_no_valid", instr_valid, 0);
    end
    pend = 0; rom_mode = 1; lat_lo = 0; lat_hi = 1;
    run_words(2, 40, "t5");
    check("t5_first_pc", seg_first, RST_PC);

`ifdef FETCH_MISALIGN_TRAP_EN
    // 6: misaligned target raises a fault entry and halts fetch
    cons_mode = 0; model_on = 0;
    tick(1'b1, 32'h42);
    check("t6_valid", instr_valid, 1);
    check("t6_fault", instr_fault, 1);
    check("t6_pc", instr_pc, 32'h42);
    check("t6_data", instr_data, 0);
    req_seen = 0;
    repeat (10) begin
      tick(1'b0, 32'h0);
      if (imem_req_valid) req_seen++;
    end
    check("t6_no_req", req_seen, 0);
    cons_mode = 1;
    tick(1'b0, 32'h0);
    model_on = 1;
    tick(1'b1, 32'h80);
    run_words(2, 40, "t6");
    check("t6_resume_pc", seg_first, 32'h80);
`endif

    // table of redirect targets under random ROM/decode timing
    rom_mode = 2; cons_mode = 2; lat_lo = 0; lat_hi = 2;
    vecs.push_back('{32'h0000_0040, 3, 32'h0000_0040, 32'h0000_0048});
    vecs.push_back('{32'h0000_1000, 2, 32'h0000_1000, 32'h0000_1004});
    vecs.push_back('{32'hFFFF_FFF8, 4, 32'hFFFF_FFF8, 32'h0000_0004});
    vecs.push_back('{32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0000});
`ifndef FETCH_MISALIGN_TRAP_EN
    vecs.push_back('{32'h0000_0103, 2, 32'h0000_0100, 32'h0000_0104});
`endif
    foreach (vecs[i]) begin
      tick(1'b1, vecs[i].target);
      run_words(vecs[i].n, 300, "vec");
      check("vec_first", seg_first, vecs[i].exp_first);
      check("vec_last", seg_last, vecs[i].exp_last);
    end

    // random redirects, back-to-back included
    n0 = xfer_total;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0)
        tick(1'b1, ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_0FFC) : 32'hFFFF_FFF0);
      else
        tick(1'b0, 32'h0);
    end
    check("rand_progress", (xfer_total - n0 > 40), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
